ex_sched: RTL and testbench

EX_SCHED -- requirements
Module: ex_sched

---
 rtl/ex_sched_pkg.sv | 23 ++
 rtl/ex_sched.sv | 135 +++++++++++++
 tb/tb_ex_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ex_sched_pkg.sv
// Purpose: shared core types for the execute-stage scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_sched_pkg;

  // Architectural register index width.
  localparam int unsigned rdest_w = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_SQUASH  = 2'd2
  } ex_sched_state_t;

  // Decoded op fields the scheduler cares about.
  typedef struct packed {
    logic               multicycle;
    logic               is_branch;
    logic               br_taken;
    logic [rdest_w-1:0] rdest;
  } decoded_op_t;

endpackage

// File: rtl/ex_sched.sv
// Purpose: execute-stage issue scheduler (ALU / multicycle / branch squash / writeback).
// Latency: issue pulses same cycle as accept; writeback and flush one cycle after.
// Backpressure: o_ready low in MC_WAIT or while a writeback is held without i_wb_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_valid / o_ready     decoded op handshake from decode
//   i_multicycle, i_is_branch, i_br_taken, i_rdest   decoded op fields
//   o_alu_en, o_mc_start  issue pulses to ALU/branch unit and multicycle unit
//   i_mc_done             multicycle result ready (pulse)
//   o_flush               fetch/decode flush pulse after a taken branch
//   o_wb_valid, o_wb_rdest, i_wb_ready   writeback request handshake
//   o_busy                scheduler not idle or writeback pending
//   o_stall_cnt           saturating count of cycles with i_valid & !o_ready
module ex_sched
  import ex_sched_pkg::*;
#(
  parameter int wd_regs_p      = 32,
  parameter int flush_cycles_p = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_multicycle,
  input  logic                 i_is_branch,
  input  logic                 i_br_taken,
  input  logic [4:0]           i_rdest,
  output logic                 o_alu_en,
  output logic                 o_mc_start,
  input  logic                 i_mc_done,
  output logic                 o_flush,
  output logic                 o_wb_valid,
  output logic [4:0]           o_wb_rdest,
  input  logic                 i_wb_ready,
  output logic                 o_busy,
  output logic [wd_regs_p-1:0] o_stall_cnt
);

  localparam int sq_w = $clog2(flush_cycles_p + 1);

  ex_sched_state_t    state;
  logic [sq_w-1:0]    sq_cnt;
  logic [rdest_w-1:0] mc_rdest;

  decoded_op_t        op;
  logic               idle;
  logic               accept;
  logic               issue_alu;
  logic               issue_mc;
  logic               take_branch;
  logic               wb_load;
  logic [rdest_w-1:0] wb_load_rdest;

  assign op = '{multicycle: i_multicycle,
                is_branch:  i_is_branch,
                br_taken:   i_br_taken,
                rdest:      i_rdest};

  assign idle = (state == ST_IDLE);

  // SQUASH keeps o_ready high so decode can drain wrong-path ops into the bin.
  assign o_ready = !rst && ((idle && (!o_wb_valid || i_wb_ready)) || (state == ST_SQUASH));
  assign accept  = i_valid && o_ready;

  // Branches always go to the ALU path, whatever the multicycle bit says.
  assign issue_alu   = accept && idle && (!op.multicycle || op.is_branch);
  assign issue_mc    = accept && idle && op.multicycle && !op.is_branch;
  assign take_branch = issue_alu && op.is_branch && op.br_taken;

  assign o_alu_en   = issue_alu;
  assign o_mc_start = issue_mc;
  assign o_busy     = !idle || o_wb_valid;

  // Writeback sources are mutually exclusive: ALU issue only in IDLE,
  // multicycle completion only in MC_WAIT. Register 0 never writes back.
  always_comb begin
    wb_load       = 1'b0;
    wb_load_rdest = op.rdest;
    if (issue_alu) begin
      wb_load = (op.rdest != '0);
    end else if ((state == ST_MC_WAIT) && i_mc_done) begin
      wb_load       = (mc_rdest != '0);
      wb_load_rdest = mc_rdest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sq_cnt      <= '0;
      mc_rdest    <= '0;
      o_flush     <= 1'b0;
      o_wb_valid  <= 1'b0;
      o_wb_rdest  <= '0;
      o_stall_cnt <= '0;
    end else begin
      o_flush <= take_branch;

      case (state)
        ST_IDLE: begin
          if (issue_mc) begin
            state    <= ST_MC_WAIT;
            mc_rdest <= op.rdest;
          end else if (take_branch) begin
            state  <= ST_SQUASH;
            sq_cnt <= sq_w'(flush_cycles_p);
          end
        end
        ST_MC_WAIT: begin
          if (i_mc_done) state <= ST_IDLE;
        end
        ST_SQUASH: begin
          sq_cnt <= sq_cnt - sq_w'(1);
          // <= also guards against ever sitting in SQUASH with a zero count.
          if (sq_cnt <= sq_w'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A new load wins over the release of the current entry.
      if (wb_load) begin
        o_wb_valid <= 1'b1;
        o_wb_rdest <= wb_load_rdest;
      end else if (i_wb_ready) begin
        o_wb_valid <= 1'b0;
      end

      if (i_valid && !o_ready && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + wd_regs_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_sched.sv
// Purpose: self-checking bench for ex_sched against a cycle-level behavioural model.
// Latency: one check set per clock, sampled on the falling edge.
// Backpressure: writeback ready and multicycle completion driven randomly.
module tb_ex_sched;
  import ex_sched_pkg::*;

  localparam int W = 4;   // narrow counter so saturation is reached
  localparam int F = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, o_ready, i_multicycle, i_is_branch, i_br_taken;
  logic [4:0]   i_rdest;
  logic         o_alu_en, o_mc_start, i_mc_done, o_flush, o_wb_valid;
  logic [4:0]   o_wb_rdest;
  logic         i_wb_ready, o_busy;
  logic [W-1:0] o_stall_cnt;

  ex_sched #(.wd_regs_p(W), .flush_cycles_p(F)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_multicycle(i_multicycle), .i_is_branch(i_is_branch), .i_br_taken(i_br_taken),
    .i_rdest(i_rdest), .o_alu_en(o_alu_en), .o_mc_start(o_mc_start),
    .i_mc_done(i_mc_done), .o_flush(o_flush), .o_wb_valid(o_wb_valid),
    .o_wb_rdest(o_wb_rdest), .i_wb_ready(i_wb_ready), .o_busy(o_busy),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: what is outstanding, as plain counts and flags.
  bit m_mc_busy;   // a multicycle op is in flight
  int m_mc_rd;
  int m_sq_left;   // wrong-path cycles still to be swallowed
  bit m_wb_v;
  int m_wb_rd;
  bit m_flush;
  int m_stall;
  int mc_delay;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mc_busy = 0; m_mc_rd = 0; m_sq_left = 0;
    m_wb_v = 0; m_wb_rd = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit mc, input bit br, input bit tk,
                      input int rd, input bit done, input bit wbr);
    bit idle, e_ready, acc, e_alu, e_mc, ld;
    int ld_rd;
    rst = r; i_valid = v; i_multicycle = mc; i_is_branch = br; i_br_taken = tk;
    i_rdest = 5'(rd); i_mc_done = done; i_wb_ready = wbr;
    @(negedge clk);
    idle    = !m_mc_busy && (m_sq_left == 0);
    e_ready = !r && ((idle && (!m_wb_v || wbr)) || (m_sq_left > 0));
    acc     = v && e_ready;
    e_alu   = acc && idle && (!mc || br);
    e_mc    = acc && idle && mc && !br;
    chk("ready",     32'(o_ready),     32'(e_ready));
    chk("alu_en",    32'(o_alu_en),    32'(e_alu));
    chk("mc_start",  32'(o_mc_start),  32'(e_mc));
    chk("flush",     32'(o_flush),     32'(m_flush));
    chk("wb_valid",  32'(o_wb_valid),  32'(m_wb_v));
    chk("wb_rdest",  32'(o_wb_rdest),  32'(m_wb_rd));
    chk("busy",      32'(o_busy),      32'(m_mc_busy || (m_sq_left > 0) || m_wb_v));
    chk("stall_cnt", 32'(o_stall_cnt), 32'(m_stall));
    if (r) begin
      model_reset();
    end else begin
      ld = 0; ld_rd = 0;
      if (e_alu && rd != 0) begin ld = 1; ld_rd = rd; end
      if (m_mc_busy && done) begin
        m_mc_busy = 0;
        if (m_mc_rd != 0) begin ld = 1; ld_rd = m_mc_rd; end
      end
      if (e_mc) begin m_mc_busy = 1; m_mc_rd = rd; end
      if (m_sq_left > 0) m_sq_left--;
      m_flush = e_alu && br && tk;
      if (m_flush) m_sq_left = F;
      if (v && !e_ready && m_stall < (1 << W) - 1) m_stall++;
      if (ld) begin m_wb_v = 1; m_wb_rd = ld_rd; end
      else if (wbr) m_wb_v = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit v, mc, br, tk, done, wbr, r;
    int rd;
    model_reset();
    mc_delay = 0;
    rst = 1; i_valid = 0; i_multicycle = 0; i_is_branch = 0; i_br_taken = 0;
    i_rdest = 0; i_mc_done = 0; i_wb_ready = 1;
    @(posedge clk); #1;

    // reset state
    step(1, 1, 0, 0, 0, 5, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // ALU op rdest 5, writeback one cycle later
    step(0, 1, 0, 0, 0, 5, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // multicycle op rdest 7, done on cycle 4, valid held to count stalls
    step(0, 1, 1, 0, 0, 7, 0, 1);
    for (int c = 1; c <= 4; c++) step(0, 1, 1, 0, 0, 7, (c == 4), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // taken branch rdest 1; two wrong-path ops dropped, third issues
    step(0, 1, 0, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0, 9, 0, 1);
    step(0, 1, 1, 0, 0, 9, 0, 1);
    step(0, 1, 0, 0, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // ALU op rdest 0: no writeback
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // writeback held for 3 cycles
    step(0, 1, 0, 0, 0, 6, 0, 1);
    for (int c = 0; c < 3; c++) step(0, 1, 0, 0, 0, 8, 0, 0);
    step(0, 1, 0, 0, 0, 8, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // reset mid MC_WAIT, then a late done
    step(0, 1, 1, 0, 0, 4, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      mc  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1);
      rd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
      wbr = ($urandom_range(0, 2) != 0);
      if (m_mc_busy) begin
        done = (mc_delay == 0);
        if (mc_delay > 0) mc_delay--;
      end else begin
        done     = ($urandom_range(0, 7) == 0);
        mc_delay = $urandom_range(0, 4);
      end
      step(r, v, mc, br, tk, rd, done, wbr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
